runlight_step_ctrl: RTL and testbench

Controller that sequences the 8-LED run-light shifter from a quadrature rotary encoder. It cleans up the encoder's A, B and push-switch pins, then issues single-cycle step commands (rotated pulse plus dir level) to the shifter. It also provides an auto-run mode in which a period timer issues steps. Manual encoder steps and auto-run steps are arbitrated onto the one step interface. Sits between the board pins and the shifter's rotated/dir inputs.

---
 rtl/runlight_step_ctrl.sv | 134 +++++++++++++
 tb/tb_runlight_step_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/runlight_step_ctrl.sv
// Step controller for the 8-LED run-light: debounces a quadrature encoder and push switch,
// and arbitrates manual detent steps against an auto-run period timer onto one step strobe.
module runlight_step_ctrl #(
  parameter int DEB_CNT     = 50000,
  parameter int AUTO_PERIOD = 12500000,
  parameter int CNT_W       = 24
) (
  input  logic clk,
  input  logic nrst,
  input  logic rot_a,
  input  logic rot_b,
  input  logic rot_btn,
  output logic rotated,
  output logic dir,
  output logic auto_mode
);

  localparam logic [CNT_W-1:0] DEB_MAX   = CNT_W'(DEB_CNT);
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // bit 0 = A, bit 1 = B, bit 2 = push switch
  logic [2:0]            sync1_q, sync1_d;
  logic [2:0]            sync2_q, sync2_d;
  logic [2:0]            stable_q, stable_d;
  logic [2:0]            prev_q, prev_d;
  logic [2:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic                  rotated_q, rotated_d;
  logic                  dir_q, dir_d;
  logic                  auto_mode_q, auto_mode_d;
  logic                  pend_q, pend_d;
  logic                  pend_dir_q, pend_dir_d;

  logic man_evt_s;
  logic man_dir_s;
  logic btn_evt_s;
  logic auto_evt_s;

  // Synchronizers, debounce and edge history
  always_comb begin
    sync1_d   = {rot_btn, rot_b, rot_a};
    sync2_d   = sync1_q;
    prev_d    = stable_q;
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        deb_cnt_d[i] = '0;
      end else if (deb_cnt_q[i] == DEB_MAX) begin
        deb_cnt_d[i] = '0;
        stable_d[i]  = ~stable_q[i];
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
      end
    end
  end

  assign man_evt_s  = stable_q[0] & ~prev_q[0];
  assign man_dir_s  = ~stable_q[1];
  assign btn_evt_s  = stable_q[2] & ~prev_q[2];
  assign auto_evt_s = auto_mode_q & (timer_q == AUTO_LAST);

  // Mode, auto timer and step arbitration
  always_comb begin
    auto_mode_d = auto_mode_q ^ btn_evt_s;
    if (!auto_mode_d || !auto_mode_q || man_evt_s) begin
      timer_d = '0;
    end else if (timer_q == AUTO_LAST) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + CNT_ONE;
    end

    rotated_d  = 1'b0;
    dir_d      = dir_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    // A manual step arriving right behind a strobe is deferred one cycle to keep a low gap
    if (rotated_q) begin
      if (man_evt_s) begin
        pend_d     = 1'b1;
        pend_dir_d = man_dir_s;
      end else begin
        pend_d     = pend_q;
      end
    end else if (pend_q) begin
      rotated_d = 1'b1;
      dir_d     = pend_dir_q;
      pend_d    = 1'b0;
    end else if (man_evt_s) begin
      rotated_d = 1'b1;
      dir_d     = man_dir_s;
    end else if (auto_evt_s) begin
      rotated_d = 1'b1;
    end else begin
      rotated_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q     <= 3'b000;
      sync2_q     <= 3'b000;
      stable_q    <= 3'b000;
      prev_q      <= 3'b000;
      deb_cnt_q   <= '0;
      timer_q     <= '0;
      rotated_q   <= 1'b0;
      dir_q       <= 1'b1;
      auto_mode_q <= 1'b0;
      pend_q      <= 1'b0;
      pend_dir_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      prev_q      <= prev_d;
      deb_cnt_q   <= deb_cnt_d;
      timer_q     <= timer_d;
      rotated_q   <= rotated_d;
      dir_q       <= dir_d;
      auto_mode_q <= auto_mode_d;
      pend_q      <= pend_d;
      pend_dir_q  <= pend_dir_d;
    end
  end

  assign rotated   = rotated_q;
  assign dir       = dir_q;
  assign auto_mode = auto_mode_q;

endmodule

// File: tb/tb_runlight_step_ctrl.sv
// Directed bench for runlight_step_ctrl with DEB_CNT=4, AUTO_PERIOD=10; expected pulse
// edges are hand-computed from the pin change (rel. edge 0 = first edge after the change).
module tb_runlight_step_ctrl;

  logic clk;
  logic nrst;
  logic rot_a;
  logic rot_b;
  logic rot_btn;
  logic rotated;
  logic dir;
  logic auto_mode;

  int n_cmp;
  int n_err;
  int pulse_cnt;
  int base;

  runlight_step_ctrl #(
    .DEB_CNT    (4),
    .AUTO_PERIOD(10),
    .CNT_W      (8)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .rot_a    (rot_a),
    .rot_b    (rot_b),
    .rot_btn  (rot_btn),
    .rotated  (rotated),
    .dir      (dir),
    .auto_mode(auto_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobes independently of the directed checks
  always @(negedge clk) begin
    if (rotated === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    pulse_cnt = 0;
    nrst      = 1'b0;
    rot_a     = 1'($urandom_range(1));
    rot_b     = 1'($urandom_range(1));
    rot_btn   = 1'($urandom_range(1));
    repeat (3) tick();
    check_eq("rst_rotated", 32'(rotated), 32'd0);
    check_eq("rst_dir", 32'(dir), 32'd1);
    check_eq("rst_auto", 32'(auto_mode), 32'd0);
    rot_a = 1'b0; rot_b = 1'b0; rot_btn = 1'b0;
    repeat (3) tick();
    nrst = 1'b1;
    base = pulse_cnt;
    repeat (50) tick();
    check_eq("rst_quiet", 32'(pulse_cnt - base), 32'd0);
    check_eq("rel_dir", 32'(dir), 32'd1);
    check_eq("rel_auto", 32'(auto_mode), 32'd0);

    // CW detent: single strobe at rel. edge 7
    rot_a = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("cw_pulse", 32'(rotated), 32'(i == 7));
    end
    check_eq("cw_dir", 32'(dir), 32'd1);

    // CCW detent
    rot_a = 1'b0;
    repeat (10) tick();
    rot_b = 1'b1;
    repeat (10) tick();
    base  = pulse_cnt;
    rot_a = 1'b1;
    repeat (12) tick();
    check_eq("ccw_count", 32'(pulse_cnt - base), 32'd1);
    check_eq("ccw_dir", 32'(dir), 32'd0);

    // Bounce: 3-cycle highs never qualify, a long hold gives one step
    rot_a = 1'b0;
    repeat (10) tick();
    base = pulse_cnt;
    for (int k = 0; k < 5; k++) begin
      rot_a = 1'b1;
      repeat (3) tick();
      rot_a = 1'b0;
      repeat (3) tick();
    end
    repeat (8) tick();
    check_eq("bounce_none", 32'(pulse_cnt - base), 32'd0);
    rot_a = 1'b1;
    repeat (12) tick();
    check_eq("bounce_hold", 32'(pulse_cnt - base), 32'd1);

    // Back to dir=1 before auto-run
    rot_a = 1'b0; rot_b = 1'b0;
    repeat (10) tick();
    rot_a = 1'b1;
    repeat (12) tick();
    check_eq("prep_dir", 32'(dir), 32'd1);

    // Auto-run, arbitration on terminal count (edge 57), second press at rel. 80 ends it at 87
    rot_btn = 1'b1;
    for (int i = 0; i < 110; i++) begin
      tick();
      check_eq("auto_pulse", 32'(rotated), 32'(i >= 17 && i <= 87 && (i - 17) % 10 == 0));
      check_eq("auto_dir", 32'(dir), 32'(i < 57));
      check_eq("auto_mode", 32'(auto_mode), 32'(i >= 7 && i < 87));
      if (i == 9)  rot_btn = 1'b0;
      if (i == 39) begin
        rot_a = 1'b0;
        rot_b = 1'b1;
      end
      if (i == 49) rot_a = 1'b1;
      if (i == 79) rot_btn = 1'b1;
      if (i == 89) rot_btn = 1'b0;
    end

    // Reset in the middle of a period count and an A debounce
    rot_btn = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      tick();
      if (i == 9) begin
        rot_btn = 1'b0;
        rot_a   = 1'b0;
      end
    end
    check_eq("mid_auto_on", 32'(auto_mode), 32'd1);
    nrst = 1'b0;
    #1;
    check_eq("mid_rst_rotated", 32'(rotated), 32'd0);
    check_eq("mid_rst_dir", 32'(dir), 32'd1);
    check_eq("mid_rst_auto", 32'(auto_mode), 32'd0);
    repeat (2) tick();
    nrst = 1'b1;
    base = pulse_cnt;
    repeat (30) tick();
    check_eq("post_rst_quiet", 32'(pulse_cnt - base), 32'd0);
    check_eq("post_rst_auto", 32'(auto_mode), 32'd0);

    rot_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("repress_auto", 32'(auto_mode), 32'(i >= 7));
      check_eq("repress_pulse", 32'(rotated), 32'(i == 17));
      check_eq("repress_dir", 32'(dir), 32'd1);
      if (i == 9) rot_btn = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
